rot_sched: RTL and testbench
============================

# rot_sched

Sequencer and two-port arbiter for the shared rotate datapath. Two requesters each present a WIDTH-bit word, a rotate amount and a direction. The block grants one requester at a time using round-robin priority, then rotates the word one bit position per clock for the requested number of steps. It returns the result with a per-requester done pulse. It sits between client logic and the rotator, so the rotator is owned and stepped by exactly one controller.

## Interface
- WIDTH, 4, data word width (≥2)
- CNT_W, 2, rotate-amount width; amounts 0..2**CNT_W-1
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A request; held high until gnt_a
- data_a  input  WIDTH  word to rotate, sampled at grant edge
- amt_a  input  CNT_W  number of single-bit rotate steps
- dir_a  input  1  0 = right ({x[0], x[WIDTH-1:1]}), 1 = left ({x[WIDTH-2:0], x[WIDTH-1]})
- req_b, data_b, amt_b, dir_b: same as above, for requester B
- gnt_a / gnt_b  output  1  registered one-cycle pulse; the request was captured
- done_a / done_b  output  1  registered one-cycle pulse; result is valid for that requester
- result  output  WIDTH  last completed rotation; held until the next done
- busy  output  1  high while in state ROT (decoded from state)

## Operation
- FSM states are IDLE and ROT. Registers:
  - work[WIDTH-1:0]
  - cnt[CNT_W-1:0]
  - dir_r
  - owner (0 = A, 1 = B)
  - last (last requester served)
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req is high, select it.
  - If both are high, select the requester other than `last`.
  - On the edge: work ← data_x, cnt ← amt_x, dir_r ← dir_x, owner ← x, gnt_x ← 1, state ← ROT.
- ROT with cnt ≠ 0: work ← one-step rotate of work per dir_r; cnt ← cnt − 1.
- ROT with cnt = 0: result ← work, done_owner ← 1, last ← owner, state ← IDLE.
- gnt and done are high for exactly one cycle and never high for both requesters at once.
- Requests are not sampled in ROT. A req held during ROT waits and is considered in IDLE.
- After gnt_x, requester x drops req_x. If req_x is still high in IDLE, it is treated as a new request with the current data/amt/dir.
- The amount is applied literally. amt ≥ WIDTH (only possible if 2**CNT_W > WIDTH) wraps naturally, giving an effective rotation of amt mod WIDTH.
- Input changes after the grant edge have no effect on the operation in flight.

## Timing
- Reset values:
  - state = IDLE
  - work = 0, cnt = 0, result = 0
  - gnt_a = gnt_b = done_a = done_b = 0
  - busy = 0
  - last = B, so A wins the first tie
- Accept edge E0 (req high in IDLE): gnt_x visible after E0; busy high after E0.
- For amt = k: rotate steps occur on E1..Ek; done_x and result update on E(k+1); busy is low after E(k+1).
- Latency from accept to done is k+1 cycles. amt = 0 gives done on E1 with result = data unchanged.
- The earliest next accept is E(k+2). Throughput is one request per k+2 cycles.
- rst high on any edge forces reset values, overriding all other activity. An in-flight operation is abandoned with no done pulse, and result returns to 0.
- Simultaneous req_a and req_b in IDLE: exactly one gnt is issued. The loser keeps req and is granted at the next IDLE evaluation after the winner's done.

## Test plan
- Reset, then req_a with data 1010, amt 1, dir 0. Required: gnt_a 1 cycle after accept, done_a 2 cycles after accept, result = 0101, busy high for 2 cycles.
- req_b with data 0011, amt 2, dir 1. Required: done_b 3 cycles after grant, result = 1100; done_a stays 0.
- req_a with data 0011, amt 3, dir 0. Required: intermediate work values 1001, 1100, 0110; result = 0110 at done_a (4 cycles after grant). Then amt 0 with data 1010: result = 1010 at done 1 cycle after gnt.
- After reset, req_a and req_b both held high continuously. Required grant order A, B, A, B…; each done precedes the next gnt; never two gnts in the same cycle.
- During ROT, change data_a/amt_a/dir_a and raise req_b. Required: result unaffected, no gnt_b until after done_a.
- Assert rst for 1 cycle mid-rotation (amt 3). Required: no done, result = 0, busy = 0 after the edge; a new req_a is accepted on the following edge.

Source files
------------

// File: rtl/rot_sched.sv
// Round-robin two-port arbiter and sequencer for the shared rotate datapath.
// Grants one requester, steps a one-bit rotator cnt times, then pulses done.
module rot_sched #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic [CNT_W-1:0] amt_a,
    input  logic             dir_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [CNT_W-1:0] amt_b,
    input  logic             dir_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic {IDLE, ROT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             done_a_q, done_a_d;
    logic             done_b_q, done_b_d;
    logic             pick_b;

    // On a tie the requester that was not served last wins.
    assign pick_b = req_b & (~req_a | ~last_q);

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_a | req_b) begin
                    work_d  = pick_b ? data_b : data_a;
                    cnt_d   = pick_b ? amt_b  : amt_a;
                    dir_d   = pick_b ? dir_b  : dir_a;
                    owner_d = pick_b;
                    gnt_a_d = ~pick_b;
                    gnt_b_d = pick_b;
                    state_d = ROT;
                end
            end
            ROT: begin
                if (cnt_q != '0) begin
                    work_d = dir_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                                   : {work_q[0], work_q[WIDTH-1:1]};
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    result_d = work_q;
                    done_a_d = ~owner_q;
                    done_b_d = owner_q;
                    last_d   = owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
        end
    end

    assign gnt_a  = gnt_a_q;
    assign gnt_b  = gnt_b_q;
    assign done_a = done_a_q;
    assign done_b = done_b_q;
    assign result = result_q;
    assign busy   = (state_q == ROT);

endmodule

// File: tb/tb_rot_sched.sv
// Bench for rot_sched: cycle-level reference model plus directed scenarios
// with literal expectations for results, latencies and grant order.
module tb_rot_sched;

    localparam int W = 4;
    localparam int C = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_a, req_b, dir_a, dir_b;
    logic [W-1:0] data_a, data_b;
    logic [C-1:0] amt_a, amt_b;
    logic         gnt_a, gnt_b, done_a, done_b, busy;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    rot_sched #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .amt_a(amt_a), .dir_a(dir_a),
        .req_b(req_b), .data_b(data_b), .amt_b(amt_b), .dir_b(dir_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Rotation expressed arithmetically: right by n equals left by W-n.
    function automatic int rot(input int x, input int n, input bit left);
        int s;
        s = n % W;
        if (!left) s = (W - s) % W;
        if (s == 0) return x;
        return ((x << s) | (x >> (W - s))) & ((1 << W) - 1);
    endfunction

    // Reference model: tracks busy time remaining and the pending answer.
    bit m_busy, m_owner, m_last;
    int m_rem, m_pend;
    bit e_ga, e_gb, e_da, e_db;
    int e_res;

    always @(posedge clk) begin
        e_ga = 0; e_gb = 0; e_da = 0; e_db = 0;
        if (rst) begin
            m_busy = 0; m_last = 1; m_rem = 0; e_res = 0;
        end else if (m_busy) begin
            if (m_rem == 0) begin
                e_res  = m_pend;
                e_da   = !m_owner;
                e_db   = m_owner;
                m_last = m_owner;
                m_busy = 0;
            end else begin
                m_rem--;
            end
        end else if (req_a || req_b) begin
            m_owner = (req_a && req_b) ? !m_last : req_b;
            m_pend  = m_owner ? rot(data_b, amt_b, dir_b)
                              : rot(data_a, amt_a, dir_a);
            m_rem   = m_owner ? int'(amt_b) : int'(amt_a);
            m_busy  = 1;
            e_ga    = !m_owner;
            e_gb    = m_owner;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt_a", gnt_a, e_ga);
            check("gnt_b", gnt_b, e_gb);
            check("done_a", done_a, e_da);
            check("done_b", done_b, e_db);
            check("result", result, e_res);
            check("busy", busy, m_busy);
        end
    end

    task automatic req(input bit b, input int d, input int a, input bit dr);
        if (b) begin
            req_b = 1; data_b = W'(d); amt_b = C'(a); dir_b = dr;
        end else begin
            req_a = 1; data_a = W'(d); amt_a = C'(a); dir_a = dr;
        end
    endtask

    task automatic wait_gnt(input bit b, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? gnt_b : gnt_a) && n < 20);
        if (b) req_b = 0; else req_a = 0;
    endtask

    task automatic wait_done(input bit b, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? done_b : done_a) && n < 20);
    endtask

    task automatic run_op(input string nm, input bit b, input int d,
                          input int a, input bit dr, input int exp_res);
        int n;
        req(b, d, a, dr);
        wait_gnt(b, n);
        check({nm, "_gnt_lat"}, n, 1);
        wait_done(b, n);
        check({nm, "_done_lat"}, n, a + 1);
        check({nm, "_res"}, result, exp_res);
    endtask

    initial begin
        int n;
        int order[4];
        int ng;
        bit seen_gb;
        rst = 1;
        req_a = 0; req_b = 0; dir_a = 0; dir_b = 0;
        data_a = '0; data_b = '0; amt_a = '0; amt_b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt_a, gnt_b, done_a, done_b}, 0);
        rst = 0;
        @(negedge clk);

        run_op("t1", 0, 4'b1010, 1, 0, 4'b0101);
        run_op("t2", 1, 4'b0011, 2, 1, 4'b1100);
        run_op("t3", 0, 4'b0011, 3, 0, 4'b0110);
        run_op("t3z", 0, 4'b1010, 0, 0, 4'b1010);
        run_op("t3l", 1, 4'b1000, 3, 1, 4'b0100);

        // Tie: both held continuously, expect A,B,A,B.
        rst = 1;
        @(negedge clk);
        rst = 0;
        req(0, 4'b0001, 1, 1);
        req(1, 4'b1000, 1, 0);
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            check("tie_one_gnt", gnt_a & gnt_b, 0);
            if (gnt_a || gnt_b) begin
                order[ng] = gnt_b;
                ng++;
            end
        end
        req_a = 0; req_b = 0;
        check("tie_count", ng, 4);
        for (int i = 0; i < 4; i++) check("tie_order", order[i], i % 2);
        repeat (4) @(negedge clk);

        // Inputs changed in flight; B waits until A is done.
        req(0, 4'b1010, 3, 1);
        wait_gnt(0, n);
        check("t5_gnt_lat", n, 1);
        req(1, 4'b0110, 0, 0);
        data_a = 4'b1111; amt_a = 2'd0; dir_a = 0;
        seen_gb = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (gnt_b) seen_gb = 1;
        end while (!done_a && n < 20);
        check("t5_done_lat", n, 4);
        check("t5_res", result, 4'b0101);
        check("t5_no_gnt_b", seen_gb, 0);
        wait_gnt(1, n);
        check("t5_b_gnt_lat", n, 1);
        wait_done(1, n);
        check("t5_b_res", result, 4'b0110);

        // Reset mid-rotation.
        req(0, 4'b1100, 3, 0);
        wait_gnt(0, n);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("t6_result", result, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done_a, 0);
        rst = 0;
        req(0, 4'b0001, 2, 1);
        wait_gnt(0, n);
        check("t6_gnt_lat", n, 1);
        wait_done(0, n);
        check("t6_res", result, 4'b0100);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
